decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/decode_stage_if.sv | 32 +++
 rtl/regfile.sv | 39 +++
 rtl/decode_stage.sv | 134 +++++++++++++
 tb/tb_decode_stage.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the decode stage: opcodes, FSM states, ID/EX record.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SLL  = 4'h6,
        OP_SRL  = 4'h7,
        OP_ADDI = 4'h8,
        OP_LW   = 4'h9,
        OP_SW   = 4'hA,
        OP_LI   = 4'hB,
        OP_BZ   = 4'hC,
        OP_JMP  = 4'hD,
        OP_JR   = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } dec_state_e;

    typedef struct packed {
        logic                valid;
        logic [DATA_W-1:0]   pc;
        opcode_e             opcode;
        logic [REG_AW-1:0]   rd;
        logic [DATA_W-1:0]   rs_data;
        logic [DATA_W-1:0]   rt_data;
        logic [DATA_W-1:0]   imm;
        logic                reg_we;
        logic                mem_rd;
        logic                mem_wr;
        logic                branch;
        logic                halt;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '0;

    function automatic logic [DATA_W-1:0] sext4(input logic [3:0] v);
        return DATA_W'($signed(v));
    endfunction

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
        return DATA_W'($signed(v));
    endfunction

    function automatic logic [DATA_W-1:0] sext12(input logic [11:0] v);
        return DATA_W'($signed(v));
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ID/EX output bus together with the downstream stall/flush controls it obeys.
interface decode_stage_if;
    import cpu_pkg::*;

    logic                stall_in;
    logic                flush;
    logic                id_valid;
    logic [DATA_W-1:0]   id_pc;
    logic [3:0]          id_opcode;
    logic [REG_AW-1:0]   id_rd;
    logic [DATA_W-1:0]   id_rs_data;
    logic [DATA_W-1:0]   id_rt_data;
    logic [DATA_W-1:0]   id_imm;
    logic                id_reg_we;
    logic                id_mem_rd;
    logic                id_mem_wr;
    logic                id_branch;
    logic                id_halt;

    modport master (
        input  stall_in, flush,
        output id_valid, id_pc, id_opcode, id_rd, id_rs_data, id_rt_data, id_imm,
               id_reg_we, id_mem_rd, id_mem_wr, id_branch, id_halt
    );

    modport slave (
        output stall_in, flush,
        input  id_valid, id_pc, id_opcode, id_rd, id_rs_data, id_rt_data, id_imm,
               id_reg_we, id_mem_rd, id_mem_wr, id_branch, id_halt
    );

endinterface

// File: rtl/regfile.sv
// 16x16 register file: two asynchronous read ports, one write port with read bypass, r0 = 0.
module regfile
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REG_AW-1:0]   ra_addr,
    input  logic [REG_AW-1:0]   rb_addr,
    output logic [DATA_W-1:0]   ra_data,
    output logic [DATA_W-1:0]   rb_data,
    input  logic                we,
    input  logic [REG_AW-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata
);

    localparam int NREGS = 1 << REG_AW;

    // r0 has no storage; it is decoded as a constant zero on the read side.
    logic [DATA_W-1:0] regs [1:NREGS-1];

    // NOTE: this array is small and architecturally required to read zero after reset,
    // so it is built from resettable flops rather than a RAM macro.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i[REG_AW-1:0]] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data = (ra_addr == '0)               ? '0    :
                     (we && waddr == ra_addr)      ? wdata : regs[ra_addr];
    assign rb_data = (rb_addr == '0)               ? '0    :
                     (we && waddr == rb_addr)      ? wdata : regs[rb_addr];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: field extraction, operand read, load-use hazard, ID/EX register, RUN/HALTED FSM.
module decode_stage
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   if_pc,
    input  logic [DATA_W-1:0]   if_inst,
    input  logic                if_inst_invalid,
    input  logic                wb_we,
    input  logic [REG_AW-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                stall_out,
    decode_stage_if.master      id_bus
);

    opcode_e            op;
    logic [REG_AW-1:0]  f_rd, f_rs, f_rt, rb_addr;
    logic [DATA_W-1:0]  ra_data, rb_data;
    logic               use_rs, use_rb, load_use;
    idex_t              dec, idex_d, idex_q;
    dec_state_e         state_d, state_q;

    assign op   = opcode_e'(if_inst[15:12]);
    assign f_rd = if_inst[11:8];
    assign f_rs = if_inst[7:4];
    assign f_rt = if_inst[3:0];

    // SW and BZ consume rd as a source; it travels on the second read port.
    assign rb_addr = (op == OP_SW || op == OP_BZ) ? f_rd : f_rt;

    regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (f_rs),
        .rb_addr (rb_addr),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        use_rs      = 1'b0;
        use_rb      = 1'b0;
        dec         = IDEX_BUBBLE;
        dec.valid   = 1'b1;
        dec.pc      = if_pc;
        dec.opcode  = op;
        dec.rd      = f_rd;
        dec.rs_data = ra_data;
        dec.rt_data = rb_data;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
                use_rs = 1'b1; use_rb = 1'b1; dec.reg_we = 1'b1;
            end
            OP_ADDI: begin
                use_rs = 1'b1; dec.imm = sext4(f_rt); dec.reg_we = 1'b1;
            end
            OP_LW: begin
                use_rs = 1'b1; dec.imm = sext4(f_rt); dec.reg_we = 1'b1; dec.mem_rd = 1'b1;
            end
            OP_SW: begin
                use_rs = 1'b1; use_rb = 1'b1; dec.imm = sext4(f_rt); dec.mem_wr = 1'b1;
            end
            OP_LI: begin
                dec.imm = sext8(if_inst[7:0]); dec.reg_we = 1'b1;
            end
            OP_BZ: begin
                use_rb = 1'b1; dec.imm = sext8(if_inst[7:0]); dec.branch = 1'b1;
            end
            OP_JMP: begin
                dec.imm = sext12(if_inst[11:0]); dec.branch = 1'b1;
            end
            OP_JR: begin
                use_rs = 1'b1; dec.branch = 1'b1;
            end
            OP_HALT: dec.halt = 1'b1;
            default: ;
        endcase
        if (f_rd == '0) begin
            dec.reg_we = 1'b0;
        end
    end

    assign load_use = idex_q.valid && idex_q.mem_rd && idex_q.rd != '0 && !if_inst_invalid
                   && ((use_rs && f_rs == idex_q.rd) || (use_rb && rb_addr == idex_q.rd));

    always_comb begin
        state_d   = state_q;
        idex_d    = idex_q;
        stall_out = id_bus.stall_in || (load_use && !id_bus.flush) || (state_q == ST_HALTED);
        if (state_q == ST_HALTED) begin
            idex_d = IDEX_BUBBLE;
        end else if (id_bus.flush) begin
            idex_d = IDEX_BUBBLE;
        end else if (id_bus.stall_in) begin
            idex_d = idex_q;
        end else if (load_use || if_inst_invalid) begin
            idex_d = IDEX_BUBBLE;
        end else begin
            idex_d = dec;
            if (dec.halt) begin
                state_d = ST_HALTED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            idex_q  <= IDEX_BUBBLE;
        end else begin
            state_q <= state_d;
            idex_q  <= idex_d;
        end
    end

    assign id_bus.id_valid   = idex_q.valid;
    assign id_bus.id_pc      = idex_q.pc;
    assign id_bus.id_opcode  = idex_q.opcode;
    assign id_bus.id_rd      = idex_q.rd;
    assign id_bus.id_rs_data = idex_q.rs_data;
    assign id_bus.id_rt_data = idex_q.rt_data;
    assign id_bus.id_imm     = idex_q.imm;
    assign id_bus.id_reg_we  = idex_q.reg_we;
    assign id_bus.id_mem_rd  = idex_q.mem_rd;
    assign id_bus.id_mem_wr  = idex_q.mem_wr;
    assign id_bus.id_branch  = idex_q.branch;
    assign id_bus.id_halt    = idex_q.halt;

endmodule

// File: tb/tb_decode_stage.sv
// Scenario bench for decode_stage: expected ID/EX contents queued on drive, compared after the edge.
module tb_decode_stage;
    import cpu_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  if_pc, if_inst, wb_data;
    logic         if_inst_invalid, wb_we, stall_out;
    logic [3:0]   wb_addr;

    decode_stage_if id_bus();

    decode_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_inst_invalid (if_inst_invalid),
        .wb_we           (wb_we),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .stall_out       (stall_out),
        .id_bus          (id_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc, inst;
        logic        inv, st, fl, we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        exp_stall;
        idex_t       exp;
    } vec_t;

    idex_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    localparam logic [4:0] C_WE = 5'b10000, C_MRD = 5'b01000, C_MWR = 5'b00100,
                           C_BR = 5'b00010, C_HLT = 5'b00001;

    function automatic idex_t mk(input logic [15:0] pc, input logic [3:0] op, rd,
                                 input logic [15:0] rs, rt, imm, input logic [4:0] ctl);
        idex_t e;
        e.valid   = 1'b1;
        e.pc      = pc;
        e.opcode  = opcode_e'(op);
        e.rd      = rd;
        e.rs_data = rs;
        e.rt_data = rt;
        e.imm     = imm;
        {e.reg_we, e.mem_rd, e.mem_wr, e.branch, e.halt} = ctl;
        return e;
    endfunction

    function automatic vec_t v(input logic [15:0] pc, inst, input logic inv, st, fl, we,
                               input logic [3:0] wa, input logic [15:0] wd,
                               input logic exp_stall, input idex_t exp);
        vec_t r;
        r.pc = pc; r.inst = inst; r.inv = inv; r.st = st; r.fl = fl;
        r.we = we; r.wa = wa; r.wd = wd; r.exp_stall = exp_stall; r.exp = exp;
        return r;
    endfunction

    function automatic idex_t observed();
        idex_t o;
        o.valid   = id_bus.id_valid;
        o.pc      = id_bus.id_pc;
        o.opcode  = opcode_e'(id_bus.id_opcode);
        o.rd      = id_bus.id_rd;
        o.rs_data = id_bus.id_rs_data;
        o.rt_data = id_bus.id_rt_data;
        o.imm     = id_bus.id_imm;
        {o.reg_we, o.mem_rd, o.mem_wr, o.branch, o.halt} =
            {id_bus.id_reg_we, id_bus.id_mem_rd, id_bus.id_mem_wr, id_bus.id_branch, id_bus.id_halt};
        return o;
    endfunction

    task automatic drive_vec(input vec_t x);
        if_pc           = x.pc;
        if_inst         = x.inst;
        if_inst_invalid = x.inv;
        id_bus.stall_in = x.st;
        id_bus.flush    = x.fl;
        wb_we           = x.we;
        wb_addr         = x.wa;
        wb_data         = x.wd;
    endtask

    task automatic test_reset();
        idex_t got;
        rst_n = 1'b0;
        drive_vec(v(16'h0, 16'h1533, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0, IDEX_BUBBLE));
        repeat (2) @(posedge clk);
        #1;
        got = observed(); vectors++;
        if (got !== IDEX_BUBBLE) begin
            miscompares++; $display("FAIL reset id_ex: got %h want %h", got, IDEX_BUBBLE);
        end
        vectors++;
        if (stall_out !== 1'b0) begin
            miscompares++; $display("FAIL reset stall_out(stall_in=0): got %b want 0", stall_out);
        end
        id_bus.stall_in = 1'b1;
        #1; vectors++;
        if (stall_out !== 1'b1) begin
            miscompares++; $display("FAIL reset stall_out(stall_in=1): got %b want 1", stall_out);
        end
        id_bus.stall_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        vec_t vs[$];
        idex_t got, want;
        vs.push_back(v(16'h10, 16'h0000, 0, 0, 0, 1, 4'd3, 16'h0042, 0, mk(16'h10, 4'h0, 0, 0, 0, 0, 0)));
        vs.push_back(v(16'h12, 16'h1533, 0, 0, 0, 0, 4'd0, 16'h0,    0, mk(16'h12, 4'h1, 5, 16'h42, 16'h42, 0, C_WE)));
        vs.push_back(v(16'h14, 16'h4100, 0, 0, 0, 1, 4'd0, 16'hFFFF, 0, mk(16'h14, 4'h4, 1, 0, 0, 0, C_WE)));
        vs.push_back(v(16'h16, 16'h2763, 0, 0, 0, 1, 4'd6, 16'h1234, 0, mk(16'h16, 4'h2, 7, 16'h1234, 16'h42, 0, C_WE)));
        vs.push_back(v(16'h18, 16'h1036, 0, 0, 0, 0, 4'd0, 16'h0,    0, mk(16'h18, 4'h1, 0, 16'h42, 16'h1234, 0, 0)));
        foreach (vs[i]) begin
            drive_vec(vs[i]); exp_q.push_back(vs[i].exp);
            #1; vectors++;
            if (stall_out !== vs[i].exp_stall) begin
                miscompares++; $display("FAIL bypass[%0d] stall_out: got %b want %b", i, stall_out, vs[i].exp_stall);
            end
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL bypass[%0d] id_ex: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_imm_ctrl();
        vec_t vs[$];
        idex_t got, want;
        vs.push_back(v(16'h20, 16'hB7F0, 0, 0, 1, 0, 0, 0, 0, IDEX_BUBBLE));
        vs.push_back(v(16'h20, 16'hB7F0, 0, 0, 0, 0, 0, 0, 0, mk(16'h20, 4'hB, 7, 0, 0, 16'hFFF0, C_WE)));
        vs.push_back(v(16'h22, 16'h826F, 0, 0, 0, 0, 0, 0, 0, mk(16'h22, 4'h8, 2, 16'h1234, 0, 16'hFFFF, C_WE)));
        vs.push_back(v(16'h24, 16'hA362, 0, 0, 0, 0, 0, 0, 0, mk(16'h24, 4'hA, 3, 16'h1234, 16'h42, 16'h0002, C_MWR)));
        vs.push_back(v(16'h26, 16'hC3FE, 0, 0, 0, 0, 0, 0, 0, mk(16'h26, 4'hC, 3, 0, 16'h42, 16'hFFFE, C_BR)));
        vs.push_back(v(16'h28, 16'hD800, 0, 0, 0, 0, 0, 0, 0, mk(16'h28, 4'hD, 8, 0, 0, 16'hF800, C_BR)));
        vs.push_back(v(16'h2A, 16'hE060, 0, 0, 0, 0, 0, 0, 0, mk(16'h2A, 4'hE, 0, 16'h1234, 0, 0, C_BR)));
        vs.push_back(v(16'h2C, 16'h1533, 1, 0, 0, 0, 0, 0, 0, IDEX_BUBBLE));
        vs.push_back(v(16'h2E, 16'h0000, 0, 0, 0, 0, 0, 0, 0, mk(16'h2E, 4'h0, 0, 0, 0, 0, 0)));
        foreach (vs[i]) begin
            drive_vec(vs[i]); exp_q.push_back(vs[i].exp);
            #1; vectors++;
            if (stall_out !== vs[i].exp_stall) begin
                miscompares++; $display("FAIL imm_ctrl[%0d] stall_out: got %b want %b", i, stall_out, vs[i].exp_stall);
            end
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL imm_ctrl[%0d] id_ex: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_load_use();
        vec_t vs[$];
        idex_t got, want;
        vs.push_back(v(16'h30, 16'h9210, 0, 0, 0, 0, 0, 0,       0, mk(16'h30, 4'h9, 2, 0, 0, 0, C_WE | C_MRD)));
        vs.push_back(v(16'h32, 16'h1421, 0, 0, 0, 1, 2, 16'h5555, 1, IDEX_BUBBLE));
        vs.push_back(v(16'h32, 16'h1421, 0, 0, 0, 0, 0, 0,       0, mk(16'h32, 4'h1, 4, 16'h5555, 0, 0, C_WE)));
        vs.push_back(v(16'h34, 16'h9210, 0, 0, 0, 0, 0, 0,       0, mk(16'h34, 4'h9, 2, 0, 0, 0, C_WE | C_MRD)));
        vs.push_back(v(16'h36, 16'h1421, 0, 0, 1, 0, 0, 0,       0, IDEX_BUBBLE));
        vs.push_back(v(16'h36, 16'h9800, 0, 0, 0, 0, 0, 0,       0, mk(16'h36, 4'h9, 8, 0, 0, 0, C_WE | C_MRD)));
        vs.push_back(v(16'h38, 16'hB580, 0, 0, 0, 0, 0, 0,       0, mk(16'h38, 4'hB, 5, 0, 0, 16'hFF80, C_WE)));
        vs.push_back(v(16'h3A, 16'h9060, 0, 0, 0, 0, 0, 0,       0, mk(16'h3A, 4'h9, 0, 16'h1234, 0, 0, C_MRD)));
        vs.push_back(v(16'h3C, 16'h4100, 0, 0, 0, 0, 0, 0,       0, mk(16'h3C, 4'h4, 1, 0, 0, 0, C_WE)));
        vs.push_back(v(16'h3E, 16'h9360, 0, 0, 0, 0, 0, 0,       0, mk(16'h3E, 4'h9, 3, 16'h1234, 0, 0, C_WE | C_MRD)));
        vs.push_back(v(16'h40, 16'hA390, 0, 0, 0, 0, 0, 0,       1, IDEX_BUBBLE));
        vs.push_back(v(16'h40, 16'hA390, 0, 0, 0, 0, 0, 0,       0, mk(16'h40, 4'hA, 3, 0, 16'h42, 0, C_MWR)));
        foreach (vs[i]) begin
            drive_vec(vs[i]); exp_q.push_back(vs[i].exp);
            #1; vectors++;
            if (stall_out !== vs[i].exp_stall) begin
                miscompares++; $display("FAIL load_use[%0d] stall_out: got %b want %b", i, stall_out, vs[i].exp_stall);
            end
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL load_use[%0d] id_ex: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_stall();
        vec_t vs[$];
        idex_t got, want, addi;
        addi = mk(16'h50, 4'h8, 10, 16'h1234, 16'h42, 16'h0003, C_WE);
        vs.push_back(v(16'h50, 16'h8A63, 0, 0, 0, 0, 0, 0, 0, addi));
        for (int k = 0; k < 3; k++) begin
            vs.push_back(v(16'h52, 16'h1111, 0, 1, 0, 0, 0, 0, 1, addi));
        end
        vs.push_back(v(16'h54, 16'h0000, 0, 0, 0, 0, 0, 0, 0, mk(16'h54, 4'h0, 0, 0, 0, 0, 0)));
        vs.push_back(v(16'h56, 16'h1111, 0, 1, 1, 0, 0, 0, 1, IDEX_BUBBLE));
        foreach (vs[i]) begin
            drive_vec(vs[i]); exp_q.push_back(vs[i].exp);
            #1; vectors++;
            if (stall_out !== vs[i].exp_stall) begin
                miscompares++; $display("FAIL stall[%0d] stall_out: got %b want %b", i, stall_out, vs[i].exp_stall);
            end
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL stall[%0d] id_ex: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_halt();
        vec_t vs[$];
        idex_t got, want;
        vs.push_back(v(16'h60, 16'hF000, 0, 0, 0, 0, 0, 0, 0, mk(16'h60, 4'hF, 0, 0, 0, 0, C_HLT)));
        vs.push_back(v(16'h62, 16'h1533, 0, 0, 0, 0, 0, 0, 1, IDEX_BUBBLE));
        vs.push_back(v(16'h62, 16'h1533, 0, 0, 1, 0, 0, 0, 1, IDEX_BUBBLE));
        vs.push_back(v(16'h62, 16'h1533, 0, 0, 0, 0, 0, 0, 1, IDEX_BUBBLE));
        foreach (vs[i]) begin
            drive_vec(vs[i]); exp_q.push_back(vs[i].exp);
            #1; vectors++;
            if (stall_out !== vs[i].exp_stall) begin
                miscompares++; $display("FAIL halt[%0d] stall_out: got %b want %b", i, stall_out, vs[i].exp_stall);
            end
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front(); vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL halt[%0d] id_ex: got %h want %h", i, got, want);
            end
        end
        // Asynchronous reset out of HALTED: must clear state and outputs without a clock edge.
        id_bus.stall_in = 1'b0;
        rst_n = 1'b0;
        #1; vectors++;
        if (stall_out !== 1'b0) begin
            miscompares++; $display("FAIL halt_reset stall_out: got %b want 0", stall_out);
        end
        got = observed(); vectors++;
        if (got !== IDEX_BUBBLE) begin
            miscompares++; $display("FAIL halt_reset id_ex: got %h want %h", got, IDEX_BUBBLE);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_vec(v(16'h70, 16'h1533, 0, 0, 0, 0, 0, 0, 0, IDEX_BUBBLE));
        exp_q.push_back(mk(16'h70, 4'h1, 5, 0, 0, 0, C_WE));
        #1; vectors++;
        if (stall_out !== 1'b0) begin
            miscompares++; $display("FAIL after_reset stall_out: got %b want 0", stall_out);
        end
        @(posedge clk); #1;
        got = observed(); want = exp_q.pop_front(); vectors++;
        if (got !== want) begin
            miscompares++; $display("FAIL after_reset id_ex: got %h want %h", got, want);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_imm_ctrl();
        test_load_use();
        test_stall();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
